// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing generator.
// Mode and region encodings plus the colour-bar on/off table.
package video_timing_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'b00,
    MODE_BARS  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_SOLID = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ACTIVE = 2'b00,
    FPORCH = 2'b01,
    SYNC   = 2'b10,
    BPORCH = 2'b11
  } region_e;

  // {R,G,B} channel on/off per bar, left to right
  localparam logic [2:0] BAR_TBL [8] = '{
    3'b111, // white
    3'b110, // yellow
    3'b011, // cyan
    3'b010, // green
    3'b101, // magenta
    3'b100, // red
    3'b001, // blue
    3'b000  // black
  };

endpackage

// File: rtl/video_timing_gen_pattern.sv
// Combinational test-pattern source.
// Ports: x, y, mode, solid_rgb in; rgb {R,G,B} out.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int HDISP   = 800,
  parameter int VDISP   = 480,
  parameter int COLOR_W = 8,
  localparam int XW = $clog2(HDISP),
  localparam int YW = $clog2(VDISP),
  localparam int RW = 3 * COLOR_W
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  mode_e         mode,
  input  logic [RW-1:0] solid_rgb,
  output logic [RW-1:0] rgb
);

  localparam int BAR_W = HDISP / 8;

  logic [31:0] xe;
  logic [31:0] ye;
  logic [31:0] bar_n;
  logic [2:0]  bar_idx;
  logic [2:0]  onoff;
  logic        odd_sq;

  always_comb begin
    xe      = 32'(x);
    ye      = 32'(y);
    bar_n   = xe / 32'(BAR_W);
    // pixels past the last full bar stay in bar 7
    bar_idx = (bar_n > 32'd7) ? 3'd7 : bar_n[2:0];
    onoff   = BAR_TBL[bar_idx];
    odd_sq  = |((xe ^ ye) & 32'd8);
    rgb     = '0;
    unique case (mode)
      MODE_BARS: rgb = {{COLOR_W{onoff[2]}},
                        {COLOR_W{onoff[1]}},
                        {COLOR_W{onoff[0]}}};
      MODE_CHECK: rgb = odd_sq ? '0 : '1;
      MODE_SOLID: rgb = solid_rgb;
      default:    rgb = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator with test-pattern source.
// Ports: pixel_clk/pixel_rst, mode, solid_rgb, pix_req/x/y/rgb
// external pixel handshake, frame_start, hs, vs, de, rgb out.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   HDISP   = 800,
  parameter int   HFP     = 40,
  parameter int   HPULSE  = 128,
  parameter int   HBP     = 88,
  parameter int   VDISP   = 480,
  parameter int   VFP     = 1,
  parameter int   VPULSE  = 3,
  parameter int   VBP     = 21,
  parameter logic HS_POL  = 1'b0,
  parameter logic VS_POL  = 1'b0,
  parameter int   COLOR_W = 8,
  localparam int XW = $clog2(HDISP),
  localparam int YW = $clog2(VDISP),
  localparam int RW = 3 * COLOR_W
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic [1:0]    mode,
  input  logic [RW-1:0] solid_rgb,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  input  logic [RW-1:0] pix_rgb,
  output logic          frame_start,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [RW-1:0] rgb
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  if (HFP < 1 || HPULSE < 1 || HBP < 1 ||
      VFP < 1 || VPULSE < 1 || VBP < 1 ||
      HDISP < 8 || VDISP < 8) begin : g_bad_params
    $error("video_timing_gen: illegal timing parameters");
  end

  // last count of each region
  localparam logic [HW-1:0] H_ACT_END = HW'(HDISP - 1);
  localparam logic [HW-1:0] H_FP_END  = HW'(HDISP + HFP - 1);
  localparam logic [HW-1:0] H_SY_END  = HW'(HDISP + HFP + HPULSE - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(VDISP - 1);
  localparam logic [VW-1:0] V_FP_END  = VW'(VDISP + VFP - 1);
  localparam logic [VW-1:0] V_SY_END  = VW'(VDISP + VFP + VPULSE - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(VTOTAL - 1);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  region_e       hreg_q, hreg_d;
  region_e       vreg_q, vreg_d;
  mode_e         mode_q, mode_d;
  logic          fs_q, fs_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [RW-1:0] rgb_q, rgb_d;
  logic [RW-1:0] pat_rgb;
  logic          line_end;
  logic          frame_end;
  logic          active;

  always_comb begin
    line_end  = (hcnt_q == H_LAST);
    frame_end = line_end && (vcnt_q == V_LAST);
    hcnt_d    = line_end ? '0 : hcnt_q + HW'(1);
    vcnt_d    = vcnt_q;
    if (line_end) begin
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end
    // mode only changes across the frame wrap
    mode_d = frame_end ? mode_e'(mode) : mode_q;
  end

  always_comb begin
    hreg_d = hreg_q;
    unique case (hreg_q)
      ACTIVE: if (hcnt_q == H_ACT_END) hreg_d = FPORCH;
      FPORCH: if (hcnt_q == H_FP_END)  hreg_d = SYNC;
      SYNC:   if (hcnt_q == H_SY_END)  hreg_d = BPORCH;
      BPORCH: if (hcnt_q == H_LAST)    hreg_d = ACTIVE;
      default: hreg_d = ACTIVE;
    endcase
  end

  always_comb begin
    vreg_d = vreg_q;
    if (line_end) begin
      unique case (vreg_q)
        ACTIVE: if (vcnt_q == V_ACT_END) vreg_d = FPORCH;
        FPORCH: if (vcnt_q == V_FP_END)  vreg_d = SYNC;
        SYNC:   if (vcnt_q == V_SY_END)  vreg_d = BPORCH;
        BPORCH: if (vcnt_q == V_LAST)    vreg_d = ACTIVE;
        default: vreg_d = ACTIVE;
      endcase
    end
  end

  always_comb begin
    pix_req = (hcnt_q < HW'(HDISP)) &&
              (vcnt_q < VW'(VDISP)) &&
              (mode_q == MODE_EXT);
    pix_x   = hcnt_q[XW-1:0];
    pix_y   = vcnt_q[YW-1:0];
  end

  video_pattern_gen #(
    .HDISP   (HDISP),
    .VDISP   (VDISP),
    .COLOR_W (COLOR_W)
  ) u_pattern (
    .x         (hcnt_q[XW-1:0]),
    .y         (vcnt_q[YW-1:0]),
    .mode      (mode_q),
    .solid_rgb (solid_rgb),
    .rgb       (pat_rgb)
  );

  always_comb begin
    active = (hreg_q == ACTIVE) && (vreg_q == ACTIVE);
    fs_d   = (hcnt_q == '0) && (vcnt_q == '0);
    hs_d   = (hreg_q == SYNC) ? HS_POL : ~HS_POL;
    vs_d   = (vreg_q == SYNC) ? VS_POL : ~VS_POL;
    de_d   = active;
    rgb_d  = '0;
    if (active) begin
      rgb_d = (mode_q == MODE_EXT) ? pix_rgb : pat_rgb;
    end
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      hreg_q <= ACTIVE;
      vreg_q <= ACTIVE;
      mode_q <= MODE_EXT;
      fs_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      de_q   <= 1'b0;
      rgb_q  <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      hreg_q <= hreg_d;
      vreg_q <= vreg_d;
      mode_q <= mode_d;
      fs_q   <= fs_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      de_q   <= de_d;
      rgb_q  <= rgb_d;
    end
  end

  assign frame_start = fs_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a 12x11 raster.
// Outputs sampled on the falling edge of the pixel clock.
module tb_video_timing_gen;

  localparam int HT = 12;
  localparam int VT = 11;
  localparam int FT = HT * VT;

  localparam logic [23:0] BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [23:0] solid_rgb = 24'h0;
  logic        pix_req;
  logic [2:0]  pix_x;
  logic [2:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start;
  logic        hs;
  logic        vs;
  logic        de;
  logic [23:0] rgb;

  int checks = 0;
  int errors = 0;
  int kk = 0;

  always #5 clk = ~clk;

  assign pix_rgb = pix_req ?
    {5'b0, pix_x, 5'b0, pix_y, 8'h55} : 24'h0;

  video_timing_gen #(
    .HDISP(8), .HFP(1), .HPULSE(2), .HBP(1),
    .VDISP(8), .VFP(1), .VPULSE(1), .VBP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8)
  ) dut (
    .pixel_clk   (clk),
    .pixel_rst   (rst),
    .mode        (mode),
    .solid_rgb   (solid_rgb),
    .pix_req     (pix_req),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .rgb         (rgb)
  );

  task automatic tick();
    @(negedge clk);
    kk++;
  endtask

  // expected rgb for counter step t under a given mode
  function automatic logic [23:0] exp_rgb(
    input int m, input int t, input logic [23:0] s);
    int h;
    int v;
    h = t % HT;
    v = (t / HT) % VT;
    if (h >= 8 || v >= 8) return 24'h0;
    case (m)
      0: return {8'(h), 8'(v), 8'h55};
      1: return BARS[h];
      2: return (((h ^ v) & 8) != 0) ? 24'h0 : 24'hFFFFFF;
      default: return s;
    endcase
  endfunction

  task automatic test_reset();
    int bad;
    int pulses;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (hs !== 1'b1) begin
      errors++;
      $display("FAIL rst_hs: got %b want 1", hs);
    end
    checks++;
    if (vs !== 1'b1) begin
      errors++;
      $display("FAIL rst_vs: got %b want 1", vs);
    end
    checks++;
    if (de !== 1'b0) begin
      errors++;
      $display("FAIL rst_de: got %b want 0", de);
    end
    checks++;
    if (rgb !== 24'h0) begin
      errors++;
      $display("FAIL rst_rgb: got %h want 0", rgb);
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_fs: got %b want 0", frame_start);
    end
    rst = 1'b0;
    kk = 0;
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_fs: got %b want 1", frame_start);
    end
    bad = 0;
    pulses = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      tick();
      if (frame_start === 1'b1) pulses++;
      if (frame_start !== ((kk % FT) == 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fs_period: %0d bad cycles want 0", bad);
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL fs_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_line_timing();
    int de_bad;
    int hs_bad;
    int vs_bad;
    int hs_low;
    int vs_low;
    int h;
    int v;
    de_bad = 0; hs_bad = 0; vs_bad = 0;
    hs_low = 0; vs_low = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      h = (kk - 1) % HT;
      v = ((kk - 1) / HT) % VT;
      if (hs === 1'b0) hs_low++;
      if (vs === 1'b0) vs_low++;
      if (de !== (h < 8 && v < 8)) de_bad++;
      if (hs !== !(h == 9 || h == 10)) hs_bad++;
      if (vs !== (v != 9)) vs_bad++;
    end
    checks++;
    if (de_bad != 0) begin
      errors++;
      $display("FAIL de_timing: %0d bad want 0", de_bad);
    end
    checks++;
    if (hs_bad != 0) begin
      errors++;
      $display("FAIL hs_timing: %0d bad want 0", hs_bad);
    end
    checks++;
    if (vs_bad != 0) begin
      errors++;
      $display("FAIL vs_timing: %0d bad want 0", vs_bad);
    end
    checks++;
    if (hs_low != 22) begin
      errors++;
      $display("FAIL hs_low: got %0d want 22", hs_low);
    end
    checks++;
    if (vs_low != 12) begin
      errors++;
      $display("FAIL vs_low: got %0d want 12", vs_low);
    end
  endtask

  task automatic test_external();
    int bad;
    int reqs;
    logic [23:0] spot;
    bad = 0;
    reqs = 0;
    spot = 24'hx;
    for (int i = 0; i < FT; i++) begin
      tick();
      if (pix_req === 1'b1) reqs++;
      if (rgb !== exp_rgb(0, kk - 1, 24'h0)) bad++;
      if (((kk - 1) % FT) == 2 * HT + 3) spot = rgb;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ext_rgb: %0d bad want 0", bad);
    end
    checks++;
    if (reqs != 64) begin
      errors++;
      $display("FAIL ext_req_count: got %0d want 64", reqs);
    end
    checks++;
    if (spot !== 24'h030255) begin
      errors++;
      $display("FAIL ext_spot: got %h want 030255", spot);
    end
  endtask

  task automatic test_bars();
    int k0;
    int bad;
    int req_bad;
    mode = 2'b01;
    k0 = kk;
    tick();
    while (((kk - 1) % FT) != 0 || kk < k0 + 2) tick();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL bars_fs: got %b want 1", frame_start);
    end
    bad = 0;
    req_bad = 0;
    for (int n = 0; n < FT; n++) begin
      if (n > 0) tick();
      if (n < 8) begin
        checks++;
        if (rgb !== BARS[n]) begin
          errors++;
          $display("FAIL bar_%0d: got %h want %h",
                   n, rgb, BARS[n]);
        end
      end
      if (rgb !== exp_rgb(1, kk - 1, 24'h0)) bad++;
      if (pix_req !== 1'b0) req_bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bars_frame: %0d bad want 0", bad);
    end
    checks++;
    if (req_bad != 0) begin
      errors++;
      $display("FAIL bars_req: %0d high want 0", req_bad);
    end
  endtask

  task automatic test_mode_switch();
    int tb;
    int bars_bad;
    int solid_bad;
    int de_cnt;
    logic [23:0] first;
    while ((kk % FT) != 3 * HT) tick();
    mode = 2'b11;
    solid_rgb = 24'h123456;
    tb = (kk / FT + 1) * FT;
    bars_bad = 0; solid_bad = 0; de_cnt = 0;
    first = 24'hx;
    while (kk - 1 < tb + FT - 1) begin
      tick();
      if (kk - 1 < tb) begin
        if (rgb !== exp_rgb(1, kk - 1, 24'h0)) bars_bad++;
      end else begin
        if (rgb !== exp_rgb(3, kk - 1, 24'h123456))
          solid_bad++;
        if (de === 1'b1) de_cnt++;
        if (kk - 1 == tb) first = rgb;
      end
    end
    checks++;
    if (bars_bad != 0) begin
      errors++;
      $display("FAIL switch_bars: %0d bad want 0", bars_bad);
    end
    checks++;
    if (solid_bad != 0) begin
      errors++;
      $display("FAIL switch_solid: %0d bad want 0", solid_bad);
    end
    checks++;
    if (de_cnt != 64) begin
      errors++;
      $display("FAIL solid_de_count: got %0d want 64", de_cnt);
    end
    checks++;
    if (first !== 24'h123456) begin
      errors++;
      $display("FAIL solid_first: got %h want 123456", first);
    end
  endtask

  task automatic test_async_reset();
    int bad;
    while ((kk % FT) != 4 * HT + 5) tick();
    checks++;
    if (pix_x !== 3'd5 || pix_y !== 3'd4) begin
      errors++;
      $display("FAIL pre_rst_xy: got %0d,%0d want 5,4",
               pix_x, pix_y);
    end
    checks++;
    if (de !== 1'b1 || rgb !== 24'h123456) begin
      errors++;
      $display("FAIL pre_rst_out: got de=%b rgb=%h want 1 123456",
               de, rgb);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (de !== 1'b0 || rgb !== 24'h0) begin
      errors++;
      $display("FAIL arst_de_rgb: got de=%b rgb=%h want 0 0",
               de, rgb);
    end
    checks++;
    if (hs !== 1'b1 || vs !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL arst_sync: got hs=%b vs=%b fs=%b want 1 1 0",
               hs, vs, frame_start);
    end
    checks++;
    if (pix_x !== 3'd0 || pix_y !== 3'd0 || pix_req !== 1'b1) begin
      errors++;
      $display("FAIL arst_cnt: got x=%0d y=%0d req=%b want 0 0 1",
               pix_x, pix_y, pix_req);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    kk = 0;
    tick();
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL arst_fs: got %b want 1", frame_start);
    end
    bad = 0;
    for (int i = 0; i < HT; i++) begin
      if (i > 0) tick();
      if (de !== (kk <= 8)) bad++;
      if (rgb !== exp_rgb(0, kk - 1, 24'h0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL arst_line: %0d bad want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_external();
    test_bars();
    test_mode_switch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
